// File: rtl/mdu_e.sv
// E-stage multiply/divide unit with HI/LO state.
// Multi-cycle mult/div with a busy counter; mthi/mtlo/mfhi/mflo.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOpE,
  input  logic [31:0] E_V1,
  input  logic [31:0] E_V2,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   ph_q, ph_d, pl_q, pl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic is_mul, is_div, sgn;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    sgn     = 1'b0;
    is_mfhi = 1'b0;
    is_mflo = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (1'b1)
      (MDUOpE == 4'd1): begin is_mul = 1'b1; sgn = 1'b1; end
      (MDUOpE == 4'd2): is_mul = 1'b1;
      (MDUOpE == 4'd3): begin is_div = 1'b1; sgn = 1'b1; end
      (MDUOpE == 4'd4): is_div = 1'b1;
      (MDUOpE == 4'd5): is_mfhi = 1'b1;
      (MDUOpE == 4'd6): is_mflo = 1'b1;
      (MDUOpE == 4'd7): is_mthi = 1'b1;
      (MDUOpE == 4'd8): is_mtlo = 1'b1;
      default: ;
    endcase
  end

  logic [63:0] a64, b64, prod;
  logic [31:0] ua, ub, uq, ur, q, r;
  logic        q_neg, r_neg, dz;

  always_comb begin
    a64 = sgn ? {{32{E_V1[31]}}, E_V1} : {32'b0, E_V1};
    b64 = sgn ? {{32{E_V2[31]}}, E_V2} : {32'b0, E_V2};
    prod = a64 * b64;
  end

  // Signed divide runs on magnitudes; 0x80000000/-1 wraps to itself.
  always_comb begin
    q_neg = sgn & (E_V1[31] ^ E_V2[31]);
    r_neg = sgn & E_V1[31];
    ua = (sgn & E_V1[31]) ? -E_V1 : E_V1;
    ub = (sgn & E_V2[31]) ? -E_V2 : E_V2;
    dz = (E_V2 == 32'd0);
    uq = dz ? 32'd0 : ua / ub;
    ur = dz ? 32'd0 : ua % ub;
    q  = q_neg ? -uq : uq;
    r  = r_neg ? -ur : ur;
  end

  assign Start = (is_mul | is_div) & ~busy_q;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    ph_d   = ph_q;
    pl_d   = pl_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d   = ph_q;
        lo_d   = pl_q;
        busy_d = 1'b0;
      end
    end else if (Start) begin
      busy_d = 1'b1;
      if (is_mul) begin
        {ph_d, pl_d} = prod;
        cnt_d = CW'(MULT_CYCLES);
      end else begin
        // divide by zero retires the current HI/LO unchanged
        {ph_d, pl_d} = dz ? {hi_q, lo_q} : {r, q};
        cnt_d = CW'(DIV_CYCLES);
      end
    end else if (is_mthi) begin
      hi_d = E_V1;
    end else if (is_mtlo) begin
      lo_d = E_V1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      ph_q   <= '0;
      pl_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      ph_q   <= ph_d;
      pl_q   <= pl_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign Busy   = busy_q;
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MDUOut = is_mfhi ? hi_q : (is_mflo ? lo_q : 32'd0);

endmodule

// File: tb/tb_mdu_e.sv
// Bench for mdu_e: vector table, corner sequences,
// and random ops against an arithmetic HI/LO model.
module tb_mdu_e;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOpE;
  logic [31:0] E_V1, E_V2;
  logic        Start, Busy;
  logic [31:0] HI, LO, MDUOut;

  int checks = 0;
  int errors = 0;

  mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDUOpE(MDUOpE),
    .E_V1(E_V1), .E_V2(E_V2), .Start(Start),
    .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tv[8];
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    int n, cyc, g;
    n = (op <= 4'd2) ? MC : DC;
    MDUOpE = op; E_V1 = a; E_V2 = b;
    #1;
    chk("start_hi", {31'b0, Start}, 32'd1);
    tick();
    chk("busy_after_start", {31'b0, Busy}, 32'd1);
    chk("start_low_busy", {31'b0, Start}, 32'd0);
    MDUOpE = 4'd0;
    E_V1 = $urandom; E_V2 = $urandom;
    cyc = 1; g = 0;
    while (Busy && g < 100) begin
      tick();
      g++;
      if (Busy) cyc++;
    end
    chk("busy_cycles", cyc, n);
  endtask

  task automatic do_mov(input logic [3:0] op,
                        input logic [31:0] a);
    MDUOpE = op; E_V1 = a; E_V2 = $urandom;
    #1;
    chk("start_mov", {31'b0, Start}, 32'd0);
    if (op == 4'd5) chk("mfhi", MDUOut, m_hi);
    if (op == 4'd6) chk("mflo", MDUOut, m_lo);
    tick();
    MDUOpE = 4'd0;
  endtask

  task automatic model(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    case (op)
      4'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      4'd2: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      4'd3: if (b != 0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sq = sa / sb; sr = sa % sb;
        m_lo = sq[31:0]; m_hi = sr[31:0];
      end
      4'd4: if (b != 0) begin
        m_lo = a / b; m_hi = a % b;
      end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: ;
    endcase
  endtask

  initial begin
    tv[0] = '{4'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tv[1] = '{4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE};
    tv[2] = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[3] = '{4'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tv[4] = '{4'd4, 32'd9, 32'd4, 32'd1, 32'd2};
    tv[5] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
    tv[6] = '{4'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    tv[7] = '{4'd2, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};

    reset = 1'b0; MDUOpE = 4'd0; E_V1 = '0; E_V2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    reset = 1'b1;
    tick();
    m_hi = 0; m_lo = 0;

    // Reset in the middle of a multiply
    do_mov(4'd7, 32'hDEAD0001); m_hi = 32'hDEAD0001;
    MDUOpE = 4'd1; E_V1 = 32'd3; E_V2 = 32'd5;
    tick();
    MDUOpE = 4'd0;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, Busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    tick(); tick();
    reset = 1'b1;
    repeat (8) tick();
    chk("post_rst_busy", {31'b0, Busy}, 32'd0);
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd0);

    // Vector table; tv[3]->tv[4] is a back-to-back start
    for (int i = 0; i < 8; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b);
      chk($sformatf("tv%0d_hi", i), HI, tv[i].hi);
      chk($sformatf("tv%0d_lo", i), LO, tv[i].lo);
    end
    m_hi = HI; m_lo = LO;

    // divu by zero keeps HI/LO
    do_mov(4'd7, 32'd1); m_hi = 32'd1;
    do_mov(4'd8, 32'd2); m_lo = 32'd2;
    run_op(4'd4, 32'd7, 32'd0);
    chk("dz_hi", HI, 32'd1);
    chk("dz_lo", LO, 32'd2);

    // mtlo then mflo the next cycle
    do_mov(4'd8, 32'h12345678); m_lo = 32'h12345678;
    do_mov(4'd6, 32'd0);
    do_mov(4'd5, 32'd0);
    MDUOpE = 4'd9; #1;
    chk("mduout_none", MDUOut, 32'd0);
    tick();

    // Ops presented while busy are ignored
    MDUOpE = 4'd1; E_V1 = 32'd3; E_V2 = 32'd4;
    tick();
    MDUOpE = 4'd7; E_V1 = 32'hBAD0BAD0;
    #1;
    chk("start_when_busy", {31'b0, Start}, 32'd0);
    tick();
    MDUOpE = 4'd8; tick();
    MDUOpE = 4'd1; tick();
    MDUOpE = 4'd0;
    repeat (MC) tick();
    chk("busy_ignored_done", {31'b0, Busy}, 32'd0);
    chk("mthi_busy_hi", HI, 32'd0);
    chk("mthi_busy_lo", LO, 32'd12);
    m_hi = 32'd0; m_lo = 32'd12;

    // Random ops against the model
    for (int k = 0; k < 60; k++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 8));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if (op <= 4'd4) begin
        run_op(op, a, b);
        model(op, a, b);
        chk($sformatf("rnd%0d_hi", k), HI, m_hi);
        chk($sformatf("rnd%0d_lo", k), LO, m_lo);
      end else begin
        do_mov(op, a);
        model(op, a, b);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
